dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 189 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory behind a pulse-based request
// interface. One request is in flight at a time; each accepted load or
// store completes with a one-cycle mem_rvalid pulse LATENCY cycles after
// the request cycle.
//
// Handshake: mem_req is a one-cycle pulse carrying wen/addr/wdata/wmask.
// It is accepted in IDLE and in RESP, and dropped (err the next cycle) in
// WAIT. Every accepted request produces exactly one mem_rvalid pulse in
// cycle t+LATENCY. mem_rdata is valid with that pulse and then holds.
// There is no back-pressure and no flush.
//
// DEPTH_WORDS must be a power of two, at least 2. LATENCY must be 1..15.
module dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  LOAD_CNT = 4'(LATENCY - 1);
    localparam bit          DIRECT   = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // FSM state; kept as a named enum so checkers can bind to it directly.
    state_t      state_q;
    state_t      state_d;

    logic [3:0]  count_q;
    logic        req_wen_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [3:0]  req_wmask_q;
    logic        drop_q;
    logic        resp_err_q;

    logic [31:0] mem [DEPTH_WORDS];

    // A request is taken whenever the block is not in WAIT.
    logic        take_req;
    // The array is accessed on every edge that lands in RESP.
    logic        do_access;
    logic        wr_en;

    // Operands of the access: with LATENCY=1 the request goes straight to
    // RESP, so the live inputs are used; otherwise the latched copy is.
    logic        acc_wen;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wmask;
    logic        acc_in_range;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0] rd_word;
    logic [31:0] load_data;

    assign take_req  = mem_req && ((state_q == IDLE) || (state_q == RESP));
    assign do_access = (state_d == RESP) && !rst;

    assign acc_wen   = take_req ? mem_wen   : req_wen_q;
    assign acc_addr  = take_req ? mem_addr  : req_addr_q;
    assign acc_wdata = take_req ? mem_wdata : req_wdata_q;
    assign acc_wmask = take_req ? mem_wmask : req_wmask_q;

    assign acc_in_range = ({1'b0, acc_addr} >= {1'b0, BASE_ADDR}) &&
                          ({1'b0, acc_addr} < LIMIT);
    assign acc_idx      = IDX_W'((acc_addr - BASE_ADDR) >> 2);
    assign rd_word      = mem[acc_idx];
    assign load_data    = rd_word >> {acc_addr[1:0], 3'b000};
    assign wr_en        = do_access && acc_wen && acc_in_range;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE/RESP accept, WAIT counts down to RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    state_d = DIRECT ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (count_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_req) begin
                    state_d = DIRECT ? RESP : WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state plus the registered error sources.
    always_comb begin
        mem_rvalid = 1'b0;
        busy       = 1'b0;
        err        = drop_q;
        case (state_q)
            WAIT: busy = 1'b1;
            RESP: begin
                busy       = 1'b1;
                mem_rvalid = 1'b1;
                err        = drop_q || resp_err_q;
            end
            default: ;
        endcase
    end

    // Latch the accepted request and run the latency counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= 4'd0;
            req_wen_q   <= 1'b0;
            req_addr_q  <= 32'd0;
            req_wdata_q <= 32'd0;
            req_wmask_q <= 4'd0;
        end else if (take_req) begin
            count_q     <= LOAD_CNT;
            req_wen_q   <= mem_wen;
            req_addr_q  <= mem_addr;
            req_wdata_q <= mem_wdata;
            req_wmask_q <= mem_wmask;
        end else if ((state_q == WAIT) && (count_q != 4'd0)) begin
            count_q <= count_q - 4'd1;
        end
    end

    // Error sources: a request arriving in WAIT, and an out-of-range access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q     <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            drop_q     <= (state_q == WAIT) && mem_req;
            resp_err_q <= do_access && !acc_in_range;
        end
    end

    // Response data: loads return the right-aligned word, stores and
    // out-of-range accesses return zero; held until the next response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rdata <= 32'd0;
        end else if (do_access) begin
            mem_rdata <= (!acc_wen && acc_in_range) ? load_data : 32'd0;
        end
    end

    // Byte-lane writes into the array; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wmask[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 instance with a response scoreboard,
// plus a LATENCY=3 instance for the dropped-request scenario.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        mem_req = 1'b0;
    logic        mem_wen = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [3:0]  mem_wmask = 4'd0;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        err;

    logic        d3_req = 1'b0;
    logic        d3_wen = 1'b0;
    logic [31:0] d3_addr = 32'd0;
    logic [31:0] d3_wdata = 32'd0;
    logic [3:0]  d3_wmask = 4'd0;
    logic        d3_rvalid;
    logic [31:0] d3_rdata;
    logic        d3_busy;
    logic        d3_err;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // {expected cycle[15:0], expected err, expected rdata}
    logic [48:0] exp_q[$];
    logic [48:0] e;
    logic [31:0] model [8];

    dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy), .err(err)
    );

    dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .mem_req(d3_req), .mem_wen(d3_wen),
        .mem_addr(d3_addr), .mem_wdata(d3_wdata), .mem_wmask(d3_wmask),
        .mem_rvalid(d3_rvalid), .mem_rdata(d3_rdata), .busy(d3_busy), .err(d3_err)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: every rvalid pops one expectation; err must not appear alone
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rvalid) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rvalid_unexpected cyc=%0d rdata=%h err=%b", cyc, mem_rdata, err);
                    n_fail++;
                end else begin
                    e = exp_q.pop_front();
                    if (cyc[15:0] !== e[48:33] || mem_rdata !== e[31:0] || err !== e[32]) begin
                        $display("FAIL response cyc=%0d exp_cyc=%0d rdata=%h exp_rdata=%h err=%b exp_err=%b",
                                 cyc[15:0], e[48:33], mem_rdata, e[31:0], err, e[32]);
                        n_fail++;
                    end
                end
            end else if (err) begin
                n_vec++;
                n_fail++;
                $display("FAIL err_stray cyc=%0d err=%b required=0", cyc, err);
            end
        end
    end

    // driver: one request pulse, expectation due LATENCY=2 cycles later
    task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, input logic [31:0] exp_rdata, input logic exp_err);
        int t;
        t = cyc + 2;
        mem_req   = 1'b1;
        mem_wen   = wen;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wmask = wmask;
        exp_q.push_back({t[15:0], exp_err, exp_rdata});
        @(posedge clk); #1;
        mem_req = 1'b0;
    endtask

    // bounded wait for all expected responses
    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // driver for the LATENCY=3 instance; lat=-1 when no response arrives
    task automatic d3_access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wmask, output logic [31:0] rd, output int lat);
        int t0;
        t0 = cyc;
        d3_req = 1'b1; d3_wen = wen; d3_addr = addr; d3_wdata = wdata; d3_wmask = wmask;
        @(posedge clk); #1;
        d3_req = 1'b0;
        lat = -1;
        rd  = 32'd0;
        for (int i = 0; i < 20; i++) begin
            if (d3_rvalid) begin
                lat = cyc - t0;
                rd  = d3_rdata;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        mem_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (mem_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got=%b want=0", mem_rvalid); end
        n_vec++; if (mem_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata got=%h want=0", mem_rdata); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b want=0", busy); end
        n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b want=0", err); end
        mem_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_word();
        // first cycle after reset release
        do_req(1'b1, BASE, 32'h1122_3344, 4'hF, 32'd0, 1'b0);
        n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_wait got=%b want=1", busy); end
        wait_idle();
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle got=%b want=0", busy); end
        do_req(1'b0, BASE, 32'd0, 4'h0, 32'h1122_3344, 1'b0);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (mem_rdata !== 32'h1122_3344) begin n_fail++; $display("FAIL rdata_hold got=%h want=11223344", mem_rdata); end
    endtask

    task automatic test_sub_word();
        do_req(1'b1, BASE + 32'd4, 32'h0066_7788, 4'hF, 32'd0, 1'b0);          wait_idle();
        do_req(1'b1, BASE + 32'd6, 32'h00AB_0000, 4'b0100, 32'd0, 1'b0);       wait_idle();
        do_req(1'b0, BASE + 32'd6, 32'd0, 4'hF, 32'h0000_00AB, 1'b0);          wait_idle();
        do_req(1'b1, BASE + 32'd4, 32'hFFFF_FFFF, 4'h0, 32'd0, 1'b0);          wait_idle();
        do_req(1'b0, BASE + 32'd4, 32'd0, 4'h0, 32'h00AB_7788, 1'b0);          wait_idle();
        do_req(1'b1, BASE + 32'd2, 32'hBEEF_0000, 4'b1100, 32'd0, 1'b0);       wait_idle();
        do_req(1'b0, BASE, 32'd0, 4'h0, 32'hBEEF_3344, 1'b0);                  wait_idle();
        do_req(1'b0, BASE + 32'd1, 32'd0, 4'h0, 32'h00BE_EF33, 1'b0);          wait_idle();
        do_req(1'b0, BASE + 32'd3, 32'd0, 4'h0, 32'h0000_00BE, 1'b0);          wait_idle();
    endtask

    task automatic test_range();
        do_req(1'b0, 32'h7FFF_FFFC, 32'd0, 4'hF, 32'd0, 1'b1);                 wait_idle();
        do_req(1'b1, BASE + 32'h1000, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b1);      wait_idle();
        do_req(1'b0, BASE + 32'h1000, 32'd0, 4'hF, 32'd0, 1'b1);               wait_idle();
        do_req(1'b0, 32'hFFFF_FFFC, 32'd0, 4'hF, 32'd0, 1'b1);                 wait_idle();
        do_req(1'b1, BASE + 32'hFFC, 32'hA5A5_5A5A, 4'hF, 32'd0, 1'b0);        wait_idle();
        do_req(1'b0, BASE + 32'hFFC, 32'd0, 4'hF, 32'hA5A5_5A5A, 1'b0);        wait_idle();
        do_req(1'b0, BASE + 32'hFFE, 32'd0, 4'hF, 32'h0000_A5A5, 1'b0);        wait_idle();
        // the discarded out-of-range store must not have aliased onto word 0
        do_req(1'b0, BASE, 32'd0, 4'hF, 32'hBEEF_3344, 1'b0);                  wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic        wen;
        int          idx;
        int          off;
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            model[i] = w;
            do_req(1'b1, BASE + 32'h40 + 32'(4 * i), w, 4'hF, 32'd0, 1'b0);
            @(posedge clk); #1;   // RESP cycle: next request issued here
        end
        for (int n = 0; n < 40; n++) begin
            wen = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 7);
            off = $urandom_range(0, 3);
            wd  = $urandom;
            wm  = 4'($urandom_range(0, 15));
            if (wen) begin
                w = model[idx];
                for (int b = 0; b < 4; b++) begin
                    if (wm[b]) w[8*b +: 8] = wd[8*b +: 8];
                end
                model[idx] = w;
                do_req(1'b1, BASE + 32'h40 + 32'(4 * idx + off), wd, wm, 32'd0, 1'b0);
            end else begin
                w = model[idx] >> (8 * off);
                do_req(1'b0, BASE + 32'h40 + 32'(4 * idx + off), wd, wm, w, 1'b0);
            end
            @(posedge clk); #1;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        wait_idle();
    endtask

    task automatic test_reset_inflight();
        do_req(1'b1, BASE + 32'h80, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0);
        wait_idle();
        mem_req = 1'b1; mem_wen = 1'b1; mem_addr = BASE + 32'h80;
        mem_wdata = 32'h1234_5678; mem_wmask = 4'hF;
        @(posedge clk); #1;
        mem_req = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL inflight_busy got=%b want=1", busy); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy got=%b want=0", busy); end
        n_vec++; if (mem_rvalid !== 1'b0) begin n_fail++; $display("FAIL async_rst_rvalid got=%b want=0", mem_rvalid); end
        @(posedge clk); #1;
        n_vec++; if (mem_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_rvalid got=%b want=0", mem_rvalid); end
        rst = 1'b0;
        do_req(1'b0, BASE + 32'h80, 32'd0, 4'hF, 32'hCAFE_F00D, 1'b0);
        wait_idle();
    endtask

    task automatic test_drop();
        logic [31:0] rd;
        int          lat;
        int          n_rv;
        int          n_er;
        int          rv_k;
        int          er_k;
        d3_access(1'b1, BASE + 32'd4, 32'h0BAD_F00D, 4'hF, rd, lat);
        n_vec++; if (lat !== 3) begin n_fail++; $display("FAIL l3_latency got=%0d want=3", lat); end
        @(posedge clk); #1;
        n_rv = 0; n_er = 0; rv_k = -1; er_k = -1;
        d3_req = 1'b1; d3_wen = 1'b1; d3_addr = BASE; d3_wdata = 32'h0102_0304; d3_wmask = 4'hF;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (d3_rvalid) begin n_rv++; rv_k = k; end
            if (d3_err) begin n_er++; er_k = k; end
            if (k == 1) begin
                d3_addr = BASE + 32'd4; d3_wdata = 32'hFFFF_FFFF;
            end else begin
                d3_req = 1'b0;
            end
        end
        n_vec++; if (n_rv !== 1 || rv_k !== 3) begin n_fail++; $display("FAIL drop_rvalid count=%0d at=%0d want 1 at 3", n_rv, rv_k); end
        n_vec++; if (n_er !== 1 || er_k !== 2) begin n_fail++; $display("FAIL drop_err count=%0d at=%0d want 1 at 2", n_er, er_k); end
        @(posedge clk); #1;
        d3_access(1'b0, BASE + 32'd4, 32'd0, 4'hF, rd, lat);
        n_vec++; if (rd !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL drop_nowrite got=%h want=0badf00d", rd); end
        @(posedge clk); #1;
        d3_access(1'b0, BASE, 32'd0, 4'hF, rd, lat);
        n_vec++; if (rd !== 32'h0102_0304) begin n_fail++; $display("FAIL drop_first got=%h want=01020304", rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_sub_word();
        test_range();
        test_back_to_back();
        test_reset_inflight();
        test_drop();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
